// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with forwarding-operand resolution for the EX stage.
// Holds the instruction through D-cache stalls while keeping forwarded operands alive.
module ex_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 7,
    parameter int IDX_W   = 5,
    parameter int FUNCT_W = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      hold_i,
    input  logic                      flush_i,
    input  logic                      id_valid_i,
    input  logic        [CTRL_W-1:0]  id_ctrl_i,
    input  logic signed [DATA_W-1:0]  id_rs1_data_i,
    input  logic signed [DATA_W-1:0]  id_rs2_data_i,
    input  logic signed [DATA_W-1:0]  id_imm_i,
    input  logic        [FUNCT_W-1:0] id_funct_i,
    input  logic        [IDX_W-1:0]   id_rs1_i,
    input  logic        [IDX_W-1:0]   id_rs2_i,
    input  logic        [IDX_W-1:0]   id_rd_i,
    input  logic        [1:0]         ForwardA_i,
    input  logic        [1:0]         ForwardB_i,
    input  logic signed [DATA_W-1:0]  mem_fwd_data_i,
    input  logic signed [DATA_W-1:0]  wb_fwd_data_i,
    output logic                      ex_valid_o,
    output logic        [CTRL_W-1:0]  ex_ctrl_o,
    output logic        [IDX_W-1:0]   ex_rs1_o,
    output logic        [IDX_W-1:0]   ex_rs2_o,
    output logic        [IDX_W-1:0]   ex_rd_o,
    output logic        [FUNCT_W-1:0] ex_funct_o,
    output logic signed [DATA_W-1:0]  alu_a_o,
    output logic signed [DATA_W-1:0]  alu_b_o,
    output logic signed [DATA_W-1:0]  store_data_o
);

    // ALUSrc sits in the least significant bit of the control word.
    localparam int ALUSRC_BIT = 0;

    logic                      r_vld_p1;
    logic        [CTRL_W-1:0]  r_ctrl_p1;
    logic        [IDX_W-1:0]   r_rs1_p1;
    logic        [IDX_W-1:0]   r_rs2_p1;
    logic        [IDX_W-1:0]   r_rd_p1;
    logic        [FUNCT_W-1:0] r_funct_p1;
    logic signed [DATA_W-1:0]  r_rs1_data_p1;
    logic signed [DATA_W-1:0]  r_rs2_data_p1;
    logic signed [DATA_W-1:0]  r_imm_p1;

    logic signed [DATA_W-1:0]  w_fwd_a;
    logic signed [DATA_W-1:0]  w_fwd_b;

    // Select 11 is reserved and falls back to the stored register value.
    function automatic logic signed [DATA_W-1:0] fwd_sel(
        input logic        [1:0]        sel,
        input logic signed [DATA_W-1:0] reg_d,
        input logic signed [DATA_W-1:0] mem_d,
        input logic signed [DATA_W-1:0] wb_d
    );
        logic signed [DATA_W-1:0] res;
        case (sel)
            2'b10:   res = mem_d;
            2'b01:   res = wb_d;
            default: res = reg_d;
        endcase
        return res;
    endfunction

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_vld_p1      <= 1'b0;
            r_ctrl_p1     <= '0;
            r_rs1_p1      <= '0;
            r_rs2_p1      <= '0;
            r_rd_p1       <= '0;
            r_funct_p1    <= '0;
            r_rs1_data_p1 <= '0;
            r_rs2_data_p1 <= '0;
            r_imm_p1      <= '0;
        end else if (hold_i) begin
            // Capture forwarded values so they outlive the producer while EX is frozen.
            r_rs1_data_p1 <= w_fwd_a;
            r_rs2_data_p1 <= w_fwd_b;
        end else if (flush_i) begin
            r_vld_p1  <= 1'b0;
            r_ctrl_p1 <= '0;
            r_rs1_p1  <= '0;
            r_rs2_p1  <= '0;
            r_rd_p1   <= '0;
        end else begin
            r_vld_p1      <= id_valid_i;
            r_ctrl_p1     <= id_valid_i ? id_ctrl_i : '0;
            r_rs1_p1      <= id_valid_i ? id_rs1_i  : '0;
            r_rs2_p1      <= id_valid_i ? id_rs2_i  : '0;
            r_rd_p1       <= id_valid_i ? id_rd_i   : '0;
            r_funct_p1    <= id_funct_i;
            r_rs1_data_p1 <= id_rs1_data_i;
            r_rs2_data_p1 <= id_rs2_data_i;
            r_imm_p1      <= id_imm_i;
        end
    end

    // ---- EX operand resolution (combinational) ----
    assign w_fwd_a = fwd_sel(ForwardA_i, r_rs1_data_p1, mem_fwd_data_i, wb_fwd_data_i);
    assign w_fwd_b = fwd_sel(ForwardB_i, r_rs2_data_p1, mem_fwd_data_i, wb_fwd_data_i);

    assign alu_a_o      = w_fwd_a;
    assign alu_b_o      = r_ctrl_p1[ALUSRC_BIT] ? r_imm_p1 : w_fwd_b;
    assign store_data_o = w_fwd_b;

    assign ex_valid_o = r_vld_p1;
    assign ex_ctrl_o  = r_ctrl_p1;
    assign ex_rs1_o   = r_rs1_p1;
    assign ex_rs2_o   = r_rs2_p1;
    assign ex_rd_o    = r_rd_p1;
    assign ex_funct_o = r_funct_p1;

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk_i and rst_i.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous active-low reset, sampled on rising clk_i.
REQ-004 hold_i  in  1  freeze ID/EX register (D-cache miss stall).
REQ-005 flush_i  in  1  replace incoming instruction with bubble (branch taken / load-use).
REQ-006 id_valid_i  in  1  ID stage holds a real instruction.
REQ-007 id_ctrl_i  in  7  {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc}.
REQ-008 id_rs1_data_i, id_rs2_data_i, id_imm_i  in  32 each  register-file reads, sign-extended immediate.
REQ-009 id_funct_i  in  10  {funct7, funct3}.
REQ-010 id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices.
REQ-011 ForwardA_i, ForwardB_i  in  2 each  forwarding select: 00 register, 10 MEM, 01 WB, 11 reserved.
REQ-012 mem_fwd_data_i, wb_fwd_data_i  in  32 each  EX/MEM ALU result, WB write-back data.
REQ-013 ex_valid_o  out  1  EX holds a real instruction.
REQ-014 ex_ctrl_o  out  7  registered control, same packing as id_ctrl_i.
REQ-015 ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  registered indices (ex_rs1_o/ex_rs2_o drive the forwarding unit).
REQ-016 ex_funct_o  out  10  registered funct.
REQ-017 alu_a_o, alu_b_o, store_data_o  out  32 each  resolved ALU operands and store data.

Function
REQ-018 Register update priority each edge SHALL be: reset, then hold_i, then flush_i, then load.
REQ-019 Load (hold_i=0, flush_i=0): all ID inputs SHALL be captured; ex_valid_o <= id_valid_i; when id_valid_i=0, ctrl and indices SHALL be captured as zero.
REQ-020 Flush (hold_i=0, flush_i=1): ex_valid_o, ex_ctrl_o, ex_rs1_o, ex_rs2_o, ex_rd_o SHALL become 0; data fields don't-care.
REQ-021 Hold (hold_i=1): ctrl, indices, funct, imm, valid SHALL retain their values; flush_i SHALL be ignored (upstream keeps flush_i asserted until hold_i drops).
REQ-022 Operand resolution (combinational): fwdA = mem_fwd_data_i if ForwardA_i=10, wb_fwd_data_i if 01, else stored rs1 data (11 treated as 00); fwdB likewise with ForwardB_i and stored rs2 data.
REQ-023 alu_a_o SHALL equal fwdA; alu_b_o SHALL equal stored imm when stored ALUSrc=1, else fwdB; store_data_o SHALL always equal fwdB.
REQ-024 Operand refresh: every held cycle, stored rs1/rs2 data SHALL be overwritten with fwdA/fwdB, so a value forwarded from WB survives after that instruction retires while EX is frozen.
REQ-025 Latency: an instruction loaded at edge N SHALL present resolved operands from edge N until the edge after hold_i is last sampled high.
REQ-026 Forwarding selects for a bubble (ex_valid_o=0) SHALL have no effect on ctrl outputs; RegWrite/MemWrite of a bubble SHALL be 0.
REQ-027 x0: ex_rs1_o/ex_rs2_o of 0 SHALL pass through unmodified; stored data for x0 SHALL be whatever the register file supplied (zero).

Reset
REQ-028 rst_i=0 at an edge SHALL clear ex_valid_o, ex_ctrl_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct_o, stored rs1/rs2 data and imm to 0, overriding hold_i and flush_i.
REQ-029 Reset asserted mid-hold SHALL discard the held instruction; first load after release SHALL behave per REQ-019.

Verification
REQ-030 Load add x3,x1,x2 (rs1 data 5, rs2 data 7), Forward 00/00 -> next cycle alu_a_o=5, alu_b_o=7, ex_rd_o=3, ex_valid_o=1.
REQ-031 Same instruction, ForwardA=10 mem_fwd=0x11, ForwardB=01 wb_fwd=0x22 -> alu_a_o=0x11, alu_b_o=0x22, store_data_o=0x22; ForwardA=11 -> alu_a_o=5.
REQ-032 ALUSrc=1, imm=0xFFFFFFFC, ForwardB=01 wb_fwd=9 -> alu_b_o=0xFFFFFFFC, store_data_o=9.
REQ-033 Hold 3 cycles, cycle 1 ForwardA=01 wb_fwd=0xAB, cycles 2-3 ForwardA=00 -> alu_a_o stays 0xAB all three cycles and after release until next load.
REQ-034 flush_i=1 with hold_i=0 -> next cycle ex_valid_o=0, ex_ctrl_o=0, ex_rd_o=0; flush_i=1 with hold_i=1 -> contents unchanged.
REQ-035 rst_i=0 during hold with valid sw in EX -> next edge all outputs zero, ex_valid_o=0.
